cond_unit: RTL
==============

// Module: cond_unit
// PURPOSE
//  Consumer of the ALU's 4-bit NZCV flags. Holds the architectural flag register,
//  evaluates the 4-bit condition field of each instruction against it, and gates
//  the register-write, memory-write and PC-select requests from the decoder.
//  Also runs an IT-style predication block covering up to 4 following instructions.
//  Sits between the decoder/ALU and the register file, data memory and PC mux.
// PARAMETERS
//  FLAG_W   4   flag width; bit order {N,Z,C,V}, bit3 = N
//  IT_MAX   4   max instructions covered by one IT block
//  CNT_W    16  perf counter width (COND_PERF_EN only)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  instr_valid  in   1  valid instruction in execute this cycle
//  stall        in   1  execute held; no state change, all gated outputs 0
//  flush        in   1  pipeline flush; aborts IT block
//  cond         in   4  instruction condition code
//  alu_flags    in   4  flags from ALU {N,Z,C,V}
//  flag_write   in   2  [1]=update N,Z  [0]=update C,V
//  reg_write_req in  1  decoder register-write request
//  mem_write_req in  1  decoder memory-write request
//  pc_src_req   in   1  decoder branch/PC-write request
//  it_start     in   1  current instruction is IT (never writes anything)
//  it_cond      in   4  IT base condition
//  it_len       in   3  IT block length, legal 1..IT_MAX
//  it_mask      in   4  bit i: 1 = slot i uses it_cond, 0 = uses it_cond^4'b0001
//  cond_ex      out  1  condition passed (combinational)
//  reg_write    out  1  reg_write_req & go
//  mem_write    out  1  mem_write_req & go
//  pc_src       out  1  pc_src_req & go
//  flags_q      out  4  architectural flag register
//  it_active    out  1  IT block in progress
//  it_err       out  1  one-cycle pulse: illegal IT request
// BEHAVIOUR
//  - Reset: flags_q=0, state IDLE, slot=0, it_err=0; gated outputs 0 (instr_valid low).
//  - go = instr_valid & ~stall & ~flush & cond_ex & ~it_start. Gated outputs are
//    combinational, 0-cycle latency. Flag update visible the cycle after.
//  - Effective cond: IDLE -> cond; ACTIVE -> it_cond if it_mask[slot] else it_cond^1.
//  - Table on flags_q: 0 EQ Z,1 NE ~Z,2 CS C,3 CC ~C,4 MI N,5 PL ~N,6 VS V,7 VC ~V,
//    8 HI C&~Z,9 LS ~C|Z,A GE N==V,B LT N!=V,C GT ~Z&(N==V),D LE Z|(N!=V),E AL 1,
//    F never (0). Else-slot of AL is F -> never.
//  - Flag reg: on edge with go, flag_write[1] loads N,Z and flag_write[0] loads C,V
//    from alu_flags; failed condition, stall or flush leaves flags_q unchanged.
//  - FSM IDLE->ACTIVE: instr_valid & it_start & ~stall & ~flush & 1<=it_len<=IT_MAX;
//    latch it_cond, it_mask, len; slot=0.
//  - ACTIVE: each instr_valid & ~stall cycle consumes a slot (executed or not);
//    after slot len-1 -> IDLE. Later slots see flags written by earlier slots.
//  - ACTIVE -> IDLE early on: flush, or pc_src=1 (taken branch), same edge.
//  - it_err pulses next cycle on it_start with it_len 0 or >IT_MAX, or it_start
//    while ACTIVE; such request is ignored (ACTIVE block continues, slot consumed).
//  - stall with instr_valid: nothing consumed, outputs 0, state frozen.
//  - Reset asserted mid-block: immediate IDLE, flags_q=0.
// CONFIGURATION
//  COND_PERF_EN defined: adds outputs exec_cnt, squash_cnt [CNT_W-1:0], reset 0;
//   per non-stalled non-IT valid instruction exec_cnt++ if cond_ex else squash_cnt++;
//   both saturate at all-ones. Undefined: ports and counters absent; no other change.
// TESTING
//  1 reset, flags_q=0, cond=0 (EQ), reg_write_req=1 -> reg_write=0; cond=E -> 1.
//  2 alu_flags=4'b0100, flag_write=2'b10, cond=E -> next cycle flags_q=4'b0100; EQ passes.
//  3 flags_q=4'b1001 (N=V): GE/GT pass, LT/LE fail; flags_q=4'b0110: HI fails, LS passes.
//  4 IT it_cond=0, it_len=3, it_mask=4'b0101, Z=1 -> slots exec,skip,exec; it_active 3 cycles.
//  5 it_len=5 -> it_err pulse, no IT; it_start while ACTIVE -> it_err, block continues.
//  6 IT len 4, taken pc_src in slot 1 -> IDLE next cycle; stall in slot -> no slot consumed.

Source files
------------

// File: rtl/cond_unit.sv
// Condition/predication unit: holds the NZCV flag register and evaluates instruction conditions.
// It runs IT-style blocks and gates the decoder's write/branch requests. Optional counters: COND_PERF_EN.
module cond_unit #(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned IT_MAX = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_write,
  input  logic              reg_write_req,
  input  logic              mem_write_req,
  input  logic              pc_src_req,
  input  logic              it_start,
  input  logic [3:0]        it_cond,
  input  logic [2:0]        it_len,
  input  logic [3:0]        it_mask,
  output logic              cond_ex,
  output logic              reg_write,
  output logic              mem_write,
  output logic              pc_src,
  output logic [FLAG_W-1:0] flags_q,
  output logic              it_active,
  output logic              it_err
`ifdef COND_PERF_EN
  ,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  squash_cnt
`endif
);

  localparam int unsigned SLOT_W = 2;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [3:0]          it_cond_q, it_cond_d;
  logic [3:0]          it_mask_q, it_mask_d;
  logic [FLAG_W-1:0]   flags_d;
  logic                it_err_q, it_err_d;

  logic                issue;
  logic                len_ok;
  logic                last_slot;
  logic [3:0]          eff_cond;
  logic                go;

  // Condition table evaluated against the architectural flags {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [FLAG_W-1:0] f);
    logic n, z, cy, v, r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cy;
      4'h3:    r = ~cy;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cy & ~z;
      4'h9:    r = ~cy | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign issue     = instr_valid & ~stall;
  assign len_ok    = (it_len != 3'd0) && (it_len <= LEN_W'(IT_MAX));
  assign last_slot = ({1'b0, slot_q} == (len_q - 3'd1));

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      len_q     <= '0;
      it_cond_q <= '0;
      it_mask_q <= '0;
      flags_q   <= '0;
      it_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      len_q     <= len_d;
      it_cond_q <= it_cond_d;
      it_mask_q <= it_mask_d;
      flags_q   <= flags_d;
      it_err_q  <= it_err_d;
    end
  end

  // Next-state: IT block sequencing, flag updates, illegal-IT detection
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    len_d     = len_q;
    it_cond_d = it_cond_q;
    it_mask_d = it_mask_q;
    flags_d   = flags_q;
    it_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue && it_start && !flush) begin
          if (len_ok) begin
            state_d   = ACTIVE;
            slot_d    = '0;
            len_d     = it_len;
            it_cond_d = it_cond;
            it_mask_d = it_mask;
          end else begin
            it_err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A flush aborts the block even while the pipeline is held
        if (flush) begin
          state_d = IDLE;
          slot_d  = '0;
        end else if (issue) begin
          it_err_d = it_start;
          if (pc_src || last_slot) begin
            state_d = IDLE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (go) begin
      if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  // Outputs: effective condition and zero-latency request gating
  always_comb begin
    eff_cond  = cond;
    cond_ex   = 1'b0;
    go        = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_src    = 1'b0;
    it_active = 1'b0;

    if (state_q == ACTIVE) begin
      it_active = 1'b1;
      eff_cond  = it_mask_q[slot_q] ? it_cond_q : (it_cond_q ^ 4'b0001);
    end
    cond_ex   = cond_eval(eff_cond, flags_q);
    go        = instr_valid & ~stall & ~flush & cond_ex & ~it_start;
    reg_write = reg_write_req & go;
    mem_write = mem_write_req & go;
    pc_src    = pc_src_req & go;
  end

  assign it_err = it_err_q;

`ifdef COND_PERF_EN
  // Saturating executed/squashed instruction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (issue && !it_start) begin
      if (cond_ex) begin
        if (exec_cnt != '1) exec_cnt <= exec_cnt + CNT_W'(1);
      end else begin
        if (squash_cnt != '1) squash_cnt <= squash_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
